wshb_slave_mem: RTL and testbench
=================================

// Module: wshb_slave_mem
// PURPOSE
//  Wishbone classic-cycle responder: 64-bit word memory with byte selects and
//  runtime-programmable wait states. Other end of the Wishbone master BFM;
//  the bench uses it as the DUT-side target for WRITE/READ/CFG_DELAY traffic.
//  Synthesisable; also usable as a scratch RAM on the ipbus-to-wishbone bridge.
// PARAMETERS
//  DEPTH      256           number of 64-bit words (power of 2, >=2)
//  BASE_ADDR  32'h0000_0000 byte address of word 0 (aligned to DEPTH*8)
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  rst        in   1   asynchronous, active-high reset
//  wb_cyc_i   in   1   bus cycle valid
//  wb_stb_i   in   1   strobe / transfer request
//  wb_we_i    in   1   1=write, 0=read
//  wb_adr_i   in   32  byte address; bits [2:0] ignored
//  wb_sel_i   in   8   byte enables; sel[n] -> dat[8n+7:8n]
//  wb_dat_i   in   64  write data
//  wb_dat_o   out  64  read data, valid when wb_ack_o=1
//  wb_ack_o   out  1   transfer done, one-cycle pulse
//  wb_err_o   out  1   transfer error, one-cycle pulse (see WSHB_SLV_ERR_EN)
//  cfg_wait_i in   8   wait states inserted before ack, sampled at accept
//  busy_o     out  1   1 while a transfer is held (WAIT or RESP state)
// BEHAVIOUR
//  Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0, FSM=IDLE, cnt=0;
//   memory contents not reset (undefined until written).
//  Word index idx = (wb_adr_i - BASE_ADDR) >> 3; in_range = adr in
//   [BASE_ADDR, BASE_ADDR+DEPTH*8-1].
//  FSM states IDLE, WAIT, RESP:
//   IDLE: cyc&stb -> latch we/adr/sel/dat, cnt<=cfg_wait_i; go WAIT if
//    cfg_wait_i!=0 else RESP.
//   WAIT: cnt decrements each cycle; cnt==1 -> RESP. cyc=0 -> IDLE (abort).
//   RESP: drive ack (or err) for exactly one cycle, commit write / load
//    wb_dat_o in same edge; next state IDLE unconditionally.
//  Latency: accept edge to ack-high = cfg_wait_i+1 cycles; min 1.
//  Back-to-back: after RESP, one IDLE cycle before next accept; stb held high
//   across ack is a new request sampled in that IDLE cycle.
//  Abort: cyc low in WAIT -> no write, no ack/err, wb_dat_o unchanged.
//   cyc low in RESP cycle is ignored (response already issued).
//  Write: only bytes with sel=1 updated; sel=0 -> ack, memory unchanged.
//  Read: wb_dat_o = full 64-bit word (sel ignored); held until next read ack.
//  ack and err never high together; both low outside RESP.
//  cfg_wait_i changes mid-transfer have no effect on the held transfer.
//  cfg_wait_i=255 -> 256-cycle latency; cnt is 8-bit, no wrap issue.
//  Reset asserted mid-transfer: immediate return to IDLE, outputs to reset
//   values, pending write discarded.
// CONFIGURATION
//  WSHB_SLV_ERR_EN defined: out-of-range address -> err pulse in RESP instead
//   of ack; no write, wb_dat_o unchanged.
//  WSHB_SLV_ERR_EN undefined: wb_err_o tied 0; address wraps, idx taken
//   modulo DEPTH (upper bits ignored); always ack.
// TESTING
//  T1 reset: rst=1 mid-WAIT -> ack=err=busy=0, dat_o=0; first post-reset
//   write acked normally.
//  T2 wait=0: write adr=0x08 sel=0xFF dat=0x1122334455667788, read 0x08 ->
//   ack 1 cycle after accept, dat_o=0x1122334455667788.
//  T3 byte sel: write 0x08 sel=0x0F dat=0xAAAAAAAA_BBBBBBBB then read ->
//   0x11223344_BBBBBBBB.
//  T4 wait=5: read -> ack exactly 6 cycles after accept, busy_o high 6 cycles;
//   change cfg_wait_i to 0 mid-wait -> still 6.
//  T5 abort: wait=4, write 0x10, drop cyc after 2 cycles -> no ack, read 0x10
//   returns prior contents.
//  T6 range (DEPTH=256): write 0x800 -> ERR_EN: err pulse, word0 unchanged;
//   no ERR_EN: ack, word 0 overwritten.

Source files
------------

// File: rtl/wshb_slave_mem.sv
// -----------------------------------------------------------------------------
// wshb_slave_mem
//   Wishbone classic-cycle responder backed by a 64-bit word memory. Each
//   transfer can be held for a runtime-programmable number of wait states.
//   Writes honour byte selects. Reads always return the full word.
//
//   Optional feature macro: WSHB_SLV_ERR_EN
//     defined   : out-of-range addresses get an err pulse instead of ack, and
//                 they neither write memory nor touch wb_dat_o.
//     undefined : wb_err_o is tied 0. The word index wraps modulo DEPTH and
//                 every transfer is acked.
//
// Parameters
//   DEPTH      number of 64-bit words (power of 2, >= 2)
//   BASE_ADDR  byte address of word 0 (aligned to DEPTH*8)
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   wb_cyc_i        bus cycle valid (dropping it during wait states aborts)
//   wb_stb_i        transfer request
//   wb_we_i         1 = write, 0 = read
//   wb_adr_i [31:0] byte address, bits [2:0] ignored
//   wb_sel_i [7:0]  byte enables, sel[n] covers dat[8n+7:8n]
//   wb_dat_i [63:0] write data
//   wb_dat_o [63:0] read data, held until the next read ack
//   wb_ack_o        one-cycle transfer-done pulse
//   wb_err_o        one-cycle transfer-error pulse
//   cfg_wait_i[7:0] wait states before the response, sampled at accept
//   busy_o          high while a transfer is held (WAIT or RESP)
//
// Handshake: a request is taken in IDLE whenever cyc&stb is high. After
//   cfg_wait_i+1 cycles, ack (or err) pulses for one cycle. That pulse
//   coincides with the IDLE cycle that follows RESP. A master that still holds
//   stb during the pulse is therefore issuing its next request.
// -----------------------------------------------------------------------------
module wshb_slave_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [7:0]  wb_sel_i,
  input  logic [63:0] wb_dat_i,
  output logic [63:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  input  logic [7:0]  cfg_wait_i,
  output logic        busy_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [AW-1:0] idx_q;
  logic [7:0]  sel_q;
  logic [63:0] wdat_q;
  logic        ok_q;
  logic        ack_q;
  logic [63:0] rdat_q;

  logic [63:0] mem [DEPTH];

  // Address decode relative to the window base. Because the base is aligned
  // to the window size, the low offset bits are the word index modulo DEPTH.
  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] idx_d;
  logic          ok_d;

  assign off      = wb_adr_i - BASE_ADDR;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx_d    = off[AW+2:3];

`ifdef WSHB_SLV_ERR_EN
  assign ok_d = in_range;
`else
  assign ok_d = 1'b1;
`endif

  // Offset bits outside the index, and the range flag in the wrapping build.
  logic unused_bits;
  assign unused_bits = ^{off, in_range};

`ifdef WSHB_SLV_ERR_EN
  logic err_q;
`endif

  // Control FSM. ack/err and read data are registered on the RESP edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 8'd0;
      wdat_q  <= 64'd0;
      ok_q    <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= 64'd0;
`ifdef WSHB_SLV_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef WSHB_SLV_ERR_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            we_q    <= wb_we_i;
            idx_q   <= idx_d;
            sel_q   <= wb_sel_i;
            wdat_q  <= wb_dat_i;
            ok_q    <= ok_d;
            cnt_q   <= cfg_wait_i;
            state_q <= (cfg_wait_i != 8'd0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          // Dropping cyc abandons the transfer without any response.
          if (!wb_cyc_i) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= S_RESP;
          end
        end
        S_RESP: begin
          // The response is committed regardless of cyc in this cycle.
          state_q <= S_IDLE;
`ifdef WSHB_SLV_ERR_EN
          if (ok_q) begin
            ack_q <= 1'b1;
            if (!we_q) rdat_q <= mem[idx_q];
          end else begin
            err_q <= 1'b1;
          end
`else
          ack_q <= 1'b1;
          if (!we_q) rdat_q <= mem[idx_q];
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset. A write lands only on the RESP edge, so a transfer
  // cut short by reset or by an abort never reaches memory.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && ok_q) begin
      for (int b = 0; b < 8; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign busy_o   = (state_q != S_IDLE);
`ifdef WSHB_SLV_ERR_EN
  assign wb_err_o = err_q;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wshb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_wshb_slave_mem
//   Directed bench for wshb_slave_mem (DEPTH=256, BASE_ADDR=0). It covers
//   reset, zero-wait and multi-wait latency, byte selects, abort, reset during
//   a transfer, and address range. Expected values are hand-computed
//   constants.
// -----------------------------------------------------------------------------
module tb_wshb_slave_mem;

  logic        clk;
  logic        rst;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [7:0]  wb_sel_i;
  logic [63:0] wb_dat_i;
  logic [63:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [7:0]  cfg_wait_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  wshb_slave_mem #(
    .DEPTH     (256),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .cfg_wait_i (cfg_wait_i),
    .busy_o     (busy_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // A single classic-cycle transfer. Inputs are driven on the falling edge
  // and outputs are sampled 1ns after the rising edge. After the accept edge,
  // cfg_wait_i is scrambled so that the held transfer must keep its own count.
  // The reported latency counts rising edges from accept to ack-high.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                         input logic [63:0] dat, input logic [7:0] wt,
                         output int lat, output int busy_n,
                         output logic [63:0] rdat, output logic is_err);
    bit done;
    done   = 0;
    lat    = -1;
    busy_n = 0;
    rdat   = '0;
    is_err = 1'b0;
    @(negedge clk);
    wb_we_i    = we;
    wb_adr_i   = adr;
    wb_sel_i   = sel;
    wb_dat_i   = dat;
    cfg_wait_i = wt;
    wb_cyc_i   = 1'b1;
    wb_stb_i   = 1'b1;
    for (int n = 1; n <= 300 && !done; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) cfg_wait_i = ~wt;
      if (wb_ack_o || wb_err_o) begin
        done   = 1;
        lat    = n - 1;
        rdat   = wb_dat_o;
        is_err = wb_err_o;
        check("ack_err_exclusive", 64'(wb_ack_o & wb_err_o), 64'd0);
      end else if (busy_o) begin
        busy_n++;
      end
    end
    if (!done) check("response_timeout", 64'd0, 64'd1);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  int          lat;
  int          busy_n;
  logic [63:0] rdat;
  logic        is_err;
  bit          seen_resp;
  bit          seen_busy;

  initial begin
    rst        = 1'b1;
    wb_cyc_i   = 1'b0;
    wb_stb_i   = 1'b0;
    wb_we_i    = 1'b0;
    wb_adr_i   = '0;
    wb_sel_i   = '0;
    wb_dat_i   = '0;
    cfg_wait_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",  64'(wb_ack_o), 64'd0);
    check("rst_err",  64'(wb_err_o), 64'd0);
    check("rst_busy", 64'(busy_o),   64'd0);
    check("rst_dat",  wb_dat_o,      64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero wait states: full-word write, then read back
    wb_xfer(1'b1, 32'h08, 8'hFF, 64'h1122334455667788, 8'd0, lat, busy_n, rdat, is_err);
    check("t2_wr_lat",  64'(lat),    64'd1);
    check("t2_wr_err",  64'(is_err), 64'd0);
    check("t2_wr_busy", 64'(busy_n), 64'd1);
    wb_xfer(1'b0, 32'h08, 8'hFF, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("t2_rd_lat",  64'(lat), 64'd1);
    check("t2_rd_dat",  rdat,     64'h1122334455667788);

    // Reset asserted during WAIT: outputs clear and the pending write is lost
    @(negedge clk);
    wb_we_i    = 1'b1;
    wb_adr_i   = 32'h08;
    wb_sel_i   = 8'hFF;
    wb_dat_i   = 64'hDEADBEEFDEADBEEF;
    cfg_wait_i = 8'd3;
    wb_cyc_i   = 1'b1;
    wb_stb_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_ack",  64'(wb_ack_o), 64'd0);
    check("t1_err",  64'(wb_err_o), 64'd0);
    check("t1_busy", 64'(busy_o),   64'd0);
    check("t1_dat",  wb_dat_o,      64'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wb_xfer(1'b1, 32'h18, 8'hFF, 64'h5555AAAA5555AAAA, 8'd0, lat, busy_n, rdat, is_err);
    check("t1_post_wr_lat", 64'(lat),    64'd1);
    check("t1_post_wr_err", 64'(is_err), 64'd0);
    wb_xfer(1'b0, 32'h08, 8'hFF, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("t1_discarded_wr", rdat, 64'h1122334455667788);

    // Byte selects: only the low four bytes are written
    wb_xfer(1'b1, 32'h08, 8'h0F, 64'hAAAAAAAABBBBBBBB, 8'd0, lat, busy_n, rdat, is_err);
    wb_xfer(1'b0, 32'h08, 8'h00, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("t3_bytesel", rdat, 64'h11223344BBBBBBBB);

    // sel=0 write is acked and leaves the word unchanged
    wb_xfer(1'b1, 32'h18, 8'h00, 64'h0123012301230123, 8'd0, lat, busy_n, rdat, is_err);
    check("sel0_lat", 64'(lat), 64'd1);
    wb_xfer(1'b0, 32'h18, 8'hFF, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("sel0_dat", rdat, 64'h5555AAAA5555AAAA);

    // Five wait states, with cfg_wait_i changed after accept
    wb_xfer(1'b0, 32'h08, 8'hFF, 64'd0, 8'd5, lat, busy_n, rdat, is_err);
    check("t4_lat",  64'(lat),    64'd6);
    check("t4_busy", 64'(busy_n), 64'd6);
    check("t4_dat",  rdat,        64'h11223344BBBBBBBB);

    // Abort: cyc dropped during WAIT
    wb_xfer(1'b1, 32'h10, 8'hFF, 64'h0123456789ABCDEF, 8'd0, lat, busy_n, rdat, is_err);
    @(negedge clk);
    wb_we_i    = 1'b1;
    wb_adr_i   = 32'h10;
    wb_sel_i   = 8'hFF;
    wb_dat_i   = 64'hFFFFFFFFFFFFFFFF;
    cfg_wait_i = 8'd4;
    wb_cyc_i   = 1'b1;
    wb_stb_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wb_cyc_i  = 1'b0;
    wb_stb_i  = 1'b0;
    wb_we_i   = 1'b0;
    seen_resp = 0;
    seen_busy = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o || wb_err_o) seen_resp = 1;
      if (busy_o) seen_busy = 1;
    end
    check("t5_no_resp", 64'(seen_resp), 64'd0);
    check("t5_idle",    64'(seen_busy), 64'd0);
    check("t5_dat_held", wb_dat_o,      64'h11223344BBBBBBBB);
    wb_xfer(1'b0, 32'h10, 8'hFF, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("t5_mem_kept", rdat, 64'h0123456789ABCDEF);

    // Maximum wait setting
    wb_xfer(1'b0, 32'h10, 8'hFF, 64'd0, 8'd255, lat, busy_n, rdat, is_err);
    check("wait255_lat", 64'(lat), 64'd256);
    check("wait255_dat", rdat,     64'h0123456789ABCDEF);

    // Out-of-range address 0x800 (one past the top of a 256-word window)
    wb_xfer(1'b1, 32'h00, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 8'd0, lat, busy_n, rdat, is_err);
    wb_xfer(1'b1, 32'h800, 8'hFF, 64'h7777777777777777, 8'd0, lat, busy_n, rdat, is_err);
    check("t6_lat", 64'(lat), 64'd1);
`ifdef WSHB_SLV_ERR_EN
    check("t6_err", 64'(is_err), 64'd1);
    wb_xfer(1'b0, 32'h00, 8'hFF, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("t6_word0", rdat, 64'h0F0F0F0F0F0F0F0F);
`else
    check("t6_err", 64'(is_err), 64'd0);
    wb_xfer(1'b0, 32'h00, 8'hFF, 64'd0, 8'd0, lat, busy_n, rdat, is_err);
    check("t6_word0", rdat, 64'h7777777777777777);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
